// File: rtl/medidor_periodo.sv
// -----------------------------------------------------------------------------
// medidor_periodo
// Measures the period of a slow (divided) clock in cycles of the fast system
// clock. It reports every measured period and flags loss of the slow clock.
// It asserts lock once enough consecutive periods have matched the expected
// division ratio. Used as a health monitor for the clock dividers.
//
// Optional feature macro: DUTY_MEAS_EN
//   defined   : a second counter measures how many cycles slow_in was high
//               during each period and reports it on high_time.
//   undefined : no high counter is built; high_time is tied to 0.
//
// Parameters
//   CNT_W    : width of the cycle counter and the period/high_time outputs
//   EXPECTED : nominal period, in clk cycles
//   TOL      : a period matches when |period-EXPECTED| <= TOL
//   LOCK_CNT : consecutive matching periods needed to assert locked (>=1)
//   TIMEOUT  : cycles without a rising edge before loss is declared (< 2**CNT_W)
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous reset, active low
//   slow_in      in   1      divided clock to monitor (asynchronous)
//   period       out  CNT_W  last measured period, in clk cycles
//   period_valid out  1      one-cycle pulse when period updates
//   high_time    out  CNT_W  cycles slow_in was high in the last period
//   locked       out  1      LOCK_CNT consecutive periods within EXPECTED+-TOL
//   timeout      out  1      no rising edge for TIMEOUT cycles
// -----------------------------------------------------------------------------
module medidor_periodo #(
    parameter int CNT_W    = 8,
    parameter int EXPECTED = 100,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slow_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] high_time,
    output logic             locked,
    output logic             timeout
);

    localparam int               MC_W   = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_V   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   EXP_V  = (CNT_W+1)'(EXPECTED);
    localparam logic [CNT_W:0]   TOL_V  = (CNT_W+1)'(TOL);
    localparam logic [MC_W-1:0]  LOCK_V = MC_W'(LOCK_CNT);
    localparam logic [MC_W-1:0]  MC_ONE = MC_W'(1);

    typedef enum logic [0:0] {
        WAIT_EDGE = 1'b0,
        COUNTING  = 1'b1
    } state_t;

    // Distance to EXPECTED is taken one bit wider so the subtraction never wraps.
    function automatic logic within_tol(input logic [CNT_W-1:0] c);
        logic [CNT_W:0] cx;
        logic [CNT_W:0] d;
        cx = {1'b0, c};
        if (cx >= EXP_V) begin
            d = cx - EXP_V;
        end else begin
            d = EXP_V - cx;
        end
        return (d <= TOL_V);
    endfunction

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync_d;
    logic             r_rise;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [MC_W-1:0]  r_match_cnt;
    logic [MC_W-1:0]  w_match_inc;
    logic             w_match;
    logic             w_cnt_at_to;
    logic [CNT_W-1:0] r_period;
    logic             r_period_valid;
    logic             r_locked;
    logic             r_timeout;

    // Two-flop synchroniser followed by a registered rising-edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_sync1  <= slow_in;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            r_rise   <= r_sync2 & ~r_sync_d;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_EDGE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, period match and saturating match-count increment.
    always_comb begin
        w_state_next = r_state;
        w_cnt_at_to  = (r_cnt == TO_V);
        w_match      = within_tol(r_cnt);
        if (r_match_cnt == LOCK_V) begin
            w_match_inc = r_match_cnt;
        end else begin
            w_match_inc = r_match_cnt + MC_ONE;
        end
        case (r_state)
            WAIT_EDGE: begin
                if (r_rise) begin
                    w_state_next = COUNTING;
                end else begin
                    w_state_next = WAIT_EDGE;
                end
            end
            COUNTING: begin
                // A rise coinciding with the timeout still counts as a period.
                if (r_rise) begin
                    w_state_next = COUNTING;
                end else if (w_cnt_at_to) begin
                    w_state_next = WAIT_EDGE;
                end else begin
                    w_state_next = COUNTING;
                end
            end
            default: begin
                w_state_next = WAIT_EDGE;
            end
        endcase
    end

    // Period counter, period/lock/timeout reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= {CNT_W{1'b0}};
            r_match_cnt    <= {MC_W{1'b0}};
            r_period       <= {CNT_W{1'b0}};
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (r_rise) begin
                r_cnt <= ONE_V;
            end else if (!w_cnt_at_to) begin
                r_cnt <= r_cnt + ONE_V;
            end
            if (r_rise) begin
                r_timeout <= 1'b0;
                // The first rise after WAIT_EDGE only starts a measurement.
                if (r_state == COUNTING) begin
                    r_period       <= r_cnt;
                    r_period_valid <= 1'b1;
                    if (w_match) begin
                        r_match_cnt <= w_match_inc;
                        r_locked    <= (w_match_inc == LOCK_V);
                    end else begin
                        r_match_cnt <= {MC_W{1'b0}};
                        r_locked    <= 1'b0;
                    end
                end
            end else if ((r_state == COUNTING) && w_cnt_at_to) begin
                r_timeout   <= 1'b1;
                r_locked    <= 1'b0;
                r_match_cnt <= {MC_W{1'b0}};
            end
        end
    end

`ifdef DUTY_MEAS_EN
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_high_time;

    // High-time counter; the sample taken on the rise cycle belongs to the new period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high_cnt  <= {CNT_W{1'b0}};
            r_high_time <= {CNT_W{1'b0}};
        end else if (r_rise) begin
            r_high_cnt <= r_sync2 ? ONE_V : {CNT_W{1'b0}};
            if (r_state == COUNTING) begin
                r_high_time <= r_high_cnt;
            end
        end else if ((r_state == COUNTING) && r_sync2 && (r_high_cnt != {CNT_W{1'b1}})) begin
            r_high_cnt <= r_high_cnt + ONE_V;
        end
    end

    assign high_time = r_high_time;
`else
    assign high_time = {CNT_W{1'b0}};
`endif

    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_medidor_periodo.sv
// -----------------------------------------------------------------------------
// tb_medidor_periodo
// Randomised bench for medidor_periodo. A list of slow_in segments (high time,
// low time, optional reset) is built, a reference model walks the list and
// predicts every period_valid pulse, timeout assertion and timeout clear with
// its absolute cycle, then a driver replays the list while a monitor checks
// every DUT event against the predictions.
// -----------------------------------------------------------------------------
module tb_medidor_periodo;

    localparam int CNT_W    = 8;
    localparam int EXPECTED = 100;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 200;
    // Cycles from driving slow_in high to seeing the resulting update.
    localparam int LAT      = 4;
`ifdef DUTY_MEAS_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             slow_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [CNT_W-1:0] high_time;
    logic             locked;
    logic             timeout;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    bit started = 1'b0;

    typedef struct {
        int cyc;
        int per;
        int hi;
        int lk;
    } ev_t;

    ev_t qv[$];
    int  qt[$];
    int  qc[$];

    int sh[$];
    int sl[$];
    int sr[$];
    int sl2[$];

    medidor_periodo #(
        .CNT_W   (CNT_W),
        .EXPECTED(EXPECTED),
        .TOL     (TOL),
        .LOCK_CNT(LOCK_CNT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .slow_in     (slow_in),
        .period      (period),
        .period_valid(period_valid),
        .high_time   (high_time),
        .locked      (locked),
        .timeout     (timeout)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_seg(input int h, input int l, input int r, input int l2);
        sh.push_back(h);
        sl.push_back(l);
        sr.push_back(r);
        sl2.push_back(l2);
    endtask

    task automatic add_rand(input int gap);
        int h;
        h = $urandom_range(gap - 1, 1);
        add_seg(h, gap - h, 0, 0);
    endtask

    // Reference model: a rise closes the previous period; a gap longer than
    // TIMEOUT is a loss event instead; lock = last LOCK_CNT periods all matched.
    task automatic model_run(input int c0, output int c_end);
        int c;
        int pk;
        int ph;
        int run;
        int gap;
        int d;
        bit cnting;
        ev_t e;
        c      = c0;
        pk     = 0;
        ph     = 0;
        run    = 0;
        cnting = 1'b0;
        for (int i = 0; i < sh.size(); i++) begin
            if (cnting) begin
                gap = c - pk;
                if (gap <= TIMEOUT) begin
                    d = gap - EXPECTED;
                    if (d < 0) d = -d;
                    if (d <= TOL) run = run + 1;
                    else run = 0;
                    e.cyc = c + LAT;
                    e.per = gap;
                    e.hi  = DUTY ? ph : 0;
                    e.lk  = (run >= LOCK_CNT) ? 1 : 0;
                    qv.push_back(e);
                end else begin
                    qt.push_back(pk + LAT + TIMEOUT);
                    qc.push_back(c + LAT);
                    run = 0;
                end
            end
            cnting = 1'b1;
            pk     = c;
            ph     = sh[i];
            c      = c + sh[i] + sl[i];
            if (sr[i] > 0) begin
                cnting = 1'b0;
                run    = 0;
                c      = c + sr[i] + sl2[i];
            end
        end
        if (cnting && (c - pk > TIMEOUT)) qt.push_back(pk + LAT + TIMEOUT);
        c_end = c;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_period_valid"}, period_valid, 0);
        chk({tag, "_high_time"}, high_time, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    // Monitor: pops a prediction whenever the DUT presents an event.
    initial begin
        int  prev_to;
        ev_t e;
        prev_to = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !started) begin
                prev_to = 0;
            end else begin
                if (period_valid) begin
                    chk("pending_valid", (qv.size() > 0) ? 1 : 0, 1);
                    if (qv.size() > 0) begin
                        e = qv.pop_front();
                        chk("valid_cycle", cyc, e.cyc);
                        chk("period", period, e.per);
                        chk("high_time", high_time, e.hi);
                        chk("locked", locked, e.lk);
                    end
                end
                if (timeout && (prev_to == 0)) begin
                    chk("pending_timeout", (qt.size() > 0) ? 1 : 0, 1);
                    if (qt.size() > 0) chk("timeout_cycle", cyc, qt.pop_front());
                    chk("locked_at_timeout", locked, 0);
                end
                if (!timeout && (prev_to == 1)) begin
                    chk("pending_clear", (qc.size() > 0) ? 1 : 0, 1);
                    if (qc.size() > 0) chk("timeout_clear_cycle", cyc, qc.pop_front());
                    chk("valid_at_clear", period_valid, 0);
                end
                prev_to = timeout ? 1 : 0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int c_end;
        rst_n   = 1'b0;
        slow_in = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Nominal 50% square wave, then a 30% duty period, then loss of clock.
        repeat (5) add_seg(50, 50, 0, 0);
        add_seg(30, 70, 0, 0);
        add_seg(50, 300, 0, 0);
        // Out-of-tolerance period: never locks.
        repeat (6) add_rand(103);
        // Alternating 99/101, one 110 breaks lock, then re-lock.
        for (int i = 0; i < 12; i++) add_rand((i % 2 == 0) ? 99 : 101);
        add_seg(55, 55, 0, 0);
        for (int i = 0; i < 5; i++) add_rand((i % 2 == 0) ? 101 : 99);
        // Exactly TIMEOUT is a period; one more cycle is a loss.
        add_seg(30, 170, 0, 0);
        add_seg(30, 171, 0, 0);
        // Lock, then reset mid-period.
        repeat (5) add_seg(50, 50, 0, 0);
        add_seg(50, 20, 3, 40);
        repeat (3) add_seg(50, 50, 0, 0);
        // Random gaps, mostly near nominal.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(3, 0) == 0) add_rand($urandom_range(230, 2));
            else add_rand($urandom_range(103, 97));
        end
        // Final loss of clock.
        add_seg(40, 260, 0, 0);

        c0 = cyc;
        model_run(c0, c_end);
        started = 1'b1;

        for (int i = 0; i < sh.size(); i++) begin
            repeat (sh[i]) begin
                slow_in = 1'b1;
                @(negedge clk);
            end
            repeat (sl[i]) begin
                slow_in = 1'b0;
                @(negedge clk);
            end
            if (sr[i] > 0) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("async_reset");
                repeat (sr[i]) @(negedge clk);
                rst_n = 1'b1;
                repeat (sl2[i]) @(negedge clk);
            end
        end
        chk("drive_end_cycle", cyc, c_end);
        repeat (10) @(negedge clk);
        chk("valid_queue_empty", qv.size(), 0);
        chk("timeout_queue_empty", qt.size(), 0);
        chk("clear_queue_empty", qc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
